// File: rtl/fetch_seq.sv
// Byte-wide instruction fetch sequencer: two-byte fetch, then hold for execute.
// Optional memory wait-state handshake via MEM_WAIT_EN (adds mem_ready port).
module fetch_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] mem_data,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  input  logic       exec_done,
  input  logic       pc_load,
  input  logic [7:0] pc_in,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  output logic [7:0] mdr,
  output logic       load_iru,
  output logic       load_irl,
  output logic       instr_valid,
  output logic [7:0] pc
);

  typedef enum logic [2:0] {
    REQ_U,
    LD_U,
    REQ_L,
    LD_L,
    EXEC
  } state_t;

  state_t state;
  state_t nxt;
  logic   accept;
  logic   in_req;

`ifdef MEM_WAIT_EN
  assign accept = mem_ready;
`else
  assign accept = 1'b1;
`endif

  assign in_req   = (state == REQ_U) || (state == REQ_L);
  assign mem_addr = pc;

  always_comb begin
    nxt = state;
    unique case (state)
      REQ_U:   nxt = accept ? LD_U : REQ_U;
      LD_U:    nxt = REQ_L;
      REQ_L:   nxt = accept ? LD_L : REQ_L;
      LD_L:    nxt = EXEC;
      EXEC:    nxt = exec_done ? REQ_U : EXEC;
      default: nxt = REQ_U;
    endcase
  end

  // Moore outputs registered from the next state so they align with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= REQ_U;
      pc          <= 8'h00;
      mdr         <= 8'h00;
      mem_rd      <= 1'b1;
      load_iru    <= 1'b0;
      load_irl    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state       <= nxt;
      mem_rd      <= (nxt == REQ_U) || (nxt == REQ_L);
      load_iru    <= (nxt == LD_U);
      load_irl    <= (nxt == LD_L);
      instr_valid <= (nxt == EXEC);
      if (in_req && accept) begin
        mdr <= mem_data;
        pc  <= pc + 8'h01;
      end else if (state == EXEC && exec_done && pc_load) begin
        pc <= pc_in;
      end
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: fetch timing, jumps, wrap, reset abort.
// Wait-state steps run only when MEM_WAIT_EN is defined.
module tb_fetch_seq;

  logic       clk;
  logic       reset;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic       exec_done;
  logic       pc_load;
  logic [7:0] pc_in;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mdr;
  logic       load_iru;
  logic       load_irl;
  logic       instr_valid;
  logic [7:0] pc;

  logic [7:0] mem [256];
  int total;
  int passed;

  assign mem_data = mem[mem_addr];

  fetch_seq dut (
    .clk         (clk),
    .reset       (reset),
    .mem_data    (mem_data),
`ifdef MEM_WAIT_EN
    .mem_ready   (mem_ready),
`endif
    .exec_done   (exec_done),
    .pc_load     (pc_load),
    .pc_in       (pc_in),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mdr         (mdr),
    .load_iru    (load_iru),
    .load_irl    (load_irl),
    .instr_valid (instr_valid),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[8'h00] = 8'hA5;
    mem[8'h01] = 8'h3C;
    mem[8'hFE] = 8'h11;
    mem[8'hFF] = 8'h22;
    mem[8'h10] = 8'h77;
    reset     = 1'b1;
    mem_ready = 1'b1;
    exec_done = 1'b0;
    pc_load   = 1'b0;
    pc_in     = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    // cycle 1: REQ_U at 00
    chk("rst_mem_rd", {7'b0, mem_rd}, 8'h01);
    chk("rst_iru", {7'b0, load_iru}, 8'h00);
    chk("rst_irl", {7'b0, load_irl}, 8'h00);
    chk("rst_valid", {7'b0, instr_valid}, 8'h00);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_mdr", mdr, 8'h00);
    tick();
    chk("c2_iru", {7'b0, load_iru}, 8'h01);
    chk("c2_mdr", mdr, 8'hA5);
    chk("c2_pc", pc, 8'h01);
    chk("c2_mem_rd", {7'b0, mem_rd}, 8'h00);
    chk("c2_irl", {7'b0, load_irl}, 8'h00);
    tick();
    chk("c3_mem_rd", {7'b0, mem_rd}, 8'h01);
    chk("c3_iru", {7'b0, load_iru}, 8'h00);
    chk("c3_addr", mem_addr, 8'h01);
    chk("c3_mdr", mdr, 8'hA5);
    tick();
    chk("c4_irl", {7'b0, load_irl}, 8'h01);
    chk("c4_iru", {7'b0, load_iru}, 8'h00);
    chk("c4_mdr", mdr, 8'h3C);
    chk("c4_pc", pc, 8'h02);
    tick();
    chk("c5_valid", {7'b0, instr_valid}, 8'h01);
    chk("c5_pc", pc, 8'h02);
    // pc_load without exec_done is ignored
    pc_load = 1'b1;
    pc_in   = 8'h99;
    tick();
    tick();
    chk("noexec_valid", {7'b0, instr_valid}, 8'h01);
    chk("noexec_pc", pc, 8'h02);
    chk("noexec_mem_rd", {7'b0, mem_rd}, 8'h00);
    // jump to 40
    exec_done = 1'b1;
    pc_in     = 8'h40;
    tick();
    chk("jmp_addr", mem_addr, 8'h40);
    chk("jmp_mem_rd", {7'b0, mem_rd}, 8'h01);
    chk("jmp_valid", {7'b0, instr_valid}, 8'h00);
    // exec_done/pc_load in REQ_U are ignored
    pc_in = 8'hFE;
    tick();
    exec_done = 1'b0;
    pc_load   = 1'b0;
    chk("ign_pc", pc, 8'h41);
    chk("ign_iru", {7'b0, load_iru}, 8'h01);
    chk("ign_mdr", mdr, 8'h40 ^ 8'h5A);
    tick();
    tick();
    chk("f2_mdr", mdr, 8'h41 ^ 8'h5A);
    chk("f2_pc", pc, 8'h42);
    tick();
    // exec_done without pc_load keeps pc
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("seq_addr", mem_addr, 8'h42);
    chk("seq_mem_rd", {7'b0, mem_rd}, 8'h01);
    tick();
    tick();
    tick();
    tick();
    chk("f3_valid", {7'b0, instr_valid}, 8'h01);
    chk("f3_pc", pc, 8'h44);
    // jump to FE and fetch across the wrap
    exec_done = 1'b1;
    pc_load   = 1'b1;
    pc_in     = 8'hFE;
    tick();
    exec_done = 1'b0;
    pc_load   = 1'b0;
    chk("wr_addr", mem_addr, 8'hFE);
    tick();
    chk("wr_mdr_u", mdr, 8'h11);
    chk("wr_pc_ff", pc, 8'hFF);
    tick();
    chk("wr_addr_ff", mem_addr, 8'hFF);
    tick();
    chk("wr_mdr_l", mdr, 8'h22);
    chk("wr_pc_00", pc, 8'h00);
    tick();
    chk("wr_valid", {7'b0, instr_valid}, 8'h01);
    chk("wr_pc_ex", pc, 8'h00);
    // jump to 10, then reset during LD_U
    exec_done = 1'b1;
    pc_load   = 1'b1;
    pc_in     = 8'h10;
    tick();
    exec_done = 1'b0;
    pc_load   = 1'b0;
    tick();
    chk("ab_iru", {7'b0, load_iru}, 8'h01);
    chk("ab_pc", pc, 8'h11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ab_iru_off", {7'b0, load_iru}, 8'h00);
    chk("ab_irl_off", {7'b0, load_irl}, 8'h00);
    chk("ab_pc0", pc, 8'h00);
    chk("ab_mem_rd", {7'b0, mem_rd}, 8'h01);
    chk("ab_mdr", mdr, 8'h00);
    tick();
    chk("ab_refetch", mdr, 8'hA5);
`ifdef MEM_WAIT_EN
    // REQ_L held three cycles by mem_ready
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ws_mem_rd", {7'b0, mem_rd}, 8'h01);
      chk("ws_pc", pc, 8'h01);
      chk("ws_mdr", mdr, 8'hA5);
      chk("ws_irl", {7'b0, load_irl}, 8'h00);
      if (i == 2) mem_ready = 1'b1;
      tick();
    end
    chk("ws_irl_on", {7'b0, load_irl}, 8'h01);
    chk("ws_mdr_l", mdr, 8'h3C);
    chk("ws_pc_l", pc, 8'h02);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
